// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one slave port between N bus masters; the owner holds until it drops cyc.
// Define ARB_TIMEOUT_EN to build the watchdog that reclaims the bus from a master stalled without ack.
module bus_rr_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned IW      = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  cyc_i,
  input  logic          ack_i,
  output logic          cyc_o,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          busy_o,
  output logic          timeout_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    mask_q;
  logic [N-1:0]    elig;
  logic            owner_cyc;

  logic [IW-1:0]   start_idx;
  logic [2*N-1:0]  elig_dbl;
  logic [N-1:0]    elig_rot;
  logic [IW-1:0]   win_off;
  logic [IW:0]     win_sum;
  logic [IW-1:0]   win_idx;
  logic            win_vld;

`ifdef ARB_TIMEOUT_EN
  logic [N-1:0]    mask_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
`else
  logic            unused_ack;
  assign unused_ack = ack_i;
  assign mask_q     = '0;
`endif

  // gnt_q is one-hot, so this selects cyc_i[owner] without an index decode
  assign owner_cyc = |(cyc_i & gnt_q);
  assign elig      = cyc_i & ~mask_q;

  // Rotate the eligible set so bit 0 is the master after the last owner,
  // take the lowest set bit, then rotate the offset back to a master index.
  always_comb begin
    start_idx = (idx_q >= IW'(N - 1)) ? '0 : idx_q + 1'b1;
    elig_dbl  = {elig, elig} >> start_idx;
    elig_rot  = elig_dbl[N-1:0];
    win_vld   = 1'b0;
    win_off   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!win_vld && elig_rot[i]) begin
        win_vld = 1'b1;
        win_off = IW'(i);
      end
    end
    win_sum = {1'b0, start_idx} + {1'b0, win_off};
    win_idx = (win_sum >= (IW+1)'(N)) ? IW'(win_sum - (IW+1)'(N)) : win_sum[IW-1:0];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    mask_d  = mask_q & cyc_i;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (ack_i) begin
          cnt_d = '0;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          // This cycle's increment would reach TIMEOUT: release instead of counting.
          state_d = IDLE;
          gnt_d   = '0;
          mask_d  = mask_q | gnt_q;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      cnt_q  <= '0;
      tmo_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign busy_o    = (state_q == GRANT);
  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign cyc_o     = busy_o & owner_cyc;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
// Builds with or without ARB_TIMEOUT_EN; watchdog scenarios use TIMEOUT=8 when it is defined.
module tb_bus_rr_arbiter;

  localparam int N = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TB_TMO = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TB_TMO = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] cyc_i = '0;
  logic         ack_i = 1'b0;
  logic         cyc_o;
  logic [N-1:0] gnt_o;
  logic [1:0]   gnt_idx_o;
  logic         busy_o;
  logic         timeout_o;

  int tests = 0;
  int fails = 0;

  bus_rr_arbiter #(.N(N), .IW(2), .TIMEOUT(TB_TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .ack_i(ack_i),
    .cyc_o(cyc_o), .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: owner (-1 = none), most recent owner, lockout set, stall count.
  int           m_owner, m_last, m_cnt, m_age;
  logic [N-1:0] m_mask;
  logic         m_tmo;
  logic [N-1:0] e_gnt;
  logic [1:0]   e_idx;
  logic         e_busy, e_cyc, e_tmo;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_cnt = 0; m_age = 0; m_mask = '0; m_tmo = 1'b0;
  endtask

  task automatic model_expect();
    e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_idx  = 2'(m_last);
    e_busy = (m_owner >= 0);
    e_cyc  = (m_owner >= 0) ? cyc_i[m_owner] : 1'b0;
    e_tmo  = m_tmo;
  endtask

  task automatic model_advance(input logic [N-1:0] c, input logic a);
    logic nt;
    bit   found;
    nt = 1'b0;
    found = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (!found && c[p] && !m_mask[p]) begin
          found = 1; m_owner = p; m_last = p; m_cnt = 0; m_age = 0;
        end
      end
    end else if (!c[m_owner]) begin
      m_owner = -1;
    end else begin
      m_age++;
      if (TMO_EN) begin
        if (a) m_cnt = 0;
        else begin
          m_cnt++;
          if (m_cnt == TB_TMO) begin
            m_mask[m_owner] = 1'b1; m_owner = -1; m_cnt = 0; nt = 1'b1;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) if (!c[k]) m_mask[k] = 1'b0;
    m_tmo = nt;
  endtask

  // Inputs are driven just after the falling edge; the model steps on the rising edge.
  task automatic drive(input logic [N-1:0] c, input logic a);
    cyc_i = c; ack_i = a; #1; model_expect();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_advance(cyc_i, ack_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; cyc_i = '0; ack_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (g[k]) r = k;
    return r;
  endfunction

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive('0, 1'b0);
      tests++;
      if ({gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o} !== {4'b0000, 2'd3, 1'b0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset c%0d: got gnt=%b idx=%0d busy=%b cyc=%b tmo=%b want gnt=0000 idx=3 busy=0 cyc=0 tmo=0",
                 i, gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o);
      end
      tick();
    end
  endtask

  task automatic test_rotation();
    int order[$];
    int gaps[$];
    int gap;
    logic [N-1:0] c, prev;
    int want[5] = '{0, 1, 2, 3, 0};
    prev = '0; gap = 0;
    for (int i = 0; i < 24; i++) begin
      c = '1;
      if (m_owner >= 0 && m_age == 3) c[m_owner] = 1'b0;
      drive(c, 1'b0);
      tests++;
      if ({gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o} !== {e_gnt, e_idx, e_busy, e_cyc, e_tmo}) begin
        fails++;
        $display("FAIL rotation c%0d: got gnt=%b idx=%0d busy=%b cyc=%b tmo=%b want %b %0d %b %b %b",
                 i, gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o, e_gnt, e_idx, e_busy, e_cyc, e_tmo);
      end
      if (i <= 1) begin
        tests++;
        if (gnt_o !== ((i == 0) ? 4'b0000 : 4'b0001)) begin
          fails++;
          $display("FAIL rotation_latency c%0d: got gnt=%b want %b", i, gnt_o, (i == 0) ? 4'b0000 : 4'b0001);
        end
      end
      if (gnt_o == '0) gap++;
      else if (gnt_o != prev) begin
        order.push_back(onehot_idx(gnt_o));
        if (order.size() > 1) gaps.push_back(gap);
        gap = 0;
      end
      prev = gnt_o;
      tick();
    end
    tests++;
    if (order.size() < 5) begin
      fails++;
      $display("FAIL rotation_count: got %0d grants want at least 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (order[k] != want[k]) begin
          fails++;
          $display("FAIL rotation_order[%0d]: got master %0d want %0d", k, order[k], want[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (gaps[k] != 1) begin
          fails++;
          $display("FAIL rotation_gap[%0d]: got %0d idle cycles want 1", k, gaps[k]);
        end
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [N-1:0] stim[13] = '{4'b0100, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1010, 4'b1010,
                               4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic [N-1:0] want[13] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                               4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0010};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(stim[i], 1'b0);
      tests++;
      if ({gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o} !== {e_gnt, e_idx, e_busy, e_cyc, e_tmo}) begin
        fails++;
        $display("FAIL no_preempt_model c%0d: got gnt=%b idx=%0d busy=%b cyc=%b tmo=%b want %b %0d %b %b %b",
                 i, gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o, e_gnt, e_idx, e_busy, e_cyc, e_tmo);
      end
      tests++;
      if (gnt_o !== want[i]) begin
        fails++;
        $display("FAIL no_preempt c%0d: got gnt=%b want %b", i, gnt_o, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_single();
    int grants;
    int gap;
    logic [N-1:0] prev;
    do_reset();
    grants = 0; gap = 0; prev = '0;
    for (int i = 0; i < 20; i++) begin
      drive((m_owner == 1 && m_age == 2) ? 4'b0000 : 4'b0010, 1'b0);
      tests++;
      if ({gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o} !== {e_gnt, e_idx, e_busy, e_cyc, e_tmo}) begin
        fails++;
        $display("FAIL single c%0d: got gnt=%b idx=%0d busy=%b cyc=%b tmo=%b want %b %0d %b %b %b",
                 i, gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o, e_gnt, e_idx, e_busy, e_cyc, e_tmo);
      end
      if (gnt_o == '0) gap++;
      else if (prev == '0) begin
        grants++;
        tests++;
        if (gnt_o !== 4'b0010 || (grants > 1 && gap != 1)) begin
          fails++;
          $display("FAIL single_grant%0d: got gnt=%b gap=%0d want gnt=0010 gap=1", grants, gnt_o, gap);
        end
        gap = 0;
      end
      prev = gnt_o;
      tick();
    end
    tests++;
    if (grants != 5) begin
      fails++;
      $display("FAIL single_count: got %0d grants want 5", grants);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int held0, pulses, gnt27, gnt20, after;
    logic m1_done, seen_pulse;
    logic [N-1:0] c;
    do_reset();
    held0 = 0; pulses = 0; m1_done = 1'b0; seen_pulse = 1'b0; after = -1; gnt27 = 0; gnt20 = 0;
    for (int i = 0; i < 31; i++) begin
      if (m_owner == 1 && m_age == 1) m1_done = 1'b1;
      c = {2'b00, ~m1_done, (i != 25)};
      drive(c, 1'b0);
      tests++;
      if ({gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o} !== {e_gnt, e_idx, e_busy, e_cyc, e_tmo}) begin
        fails++;
        $display("FAIL timeout_model c%0d: got gnt=%b idx=%0d busy=%b cyc=%b tmo=%b want %b %0d %b %b %b",
                 i, gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o, e_gnt, e_idx, e_busy, e_cyc, e_tmo);
      end
      if (timeout_o === 1'b1) begin pulses++; seen_pulse = 1'b1; end
      if (!seen_pulse && gnt_o == 4'b0001) held0++;
      if (seen_pulse && after < 0 && gnt_o != '0) after = onehot_idx(gnt_o);
      if (i == 20) gnt20 = int'(gnt_o);
      if (i == 27) gnt27 = int'(gnt_o);
      tick();
    end
    tests++;
    if (held0 != TB_TMO) begin
      fails++; $display("FAIL timeout_hold: got %0d grant cycles want %0d", held0, TB_TMO);
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL timeout_pulses: got %0d want 1", pulses);
    end
    tests++;
    if (after != 1) begin
      fails++; $display("FAIL timeout_next: got master %0d want 1", after);
    end
    tests++;
    if (gnt20 != 0) begin
      fails++; $display("FAIL timeout_masked: got gnt=%b want 0000", gnt20[3:0]);
    end
    tests++;
    if (gnt27 != 1) begin
      fails++; $display("FAIL timeout_regrant: got gnt=%b want 0001", gnt27[3:0]);
    end
  endtask
`else
  task automatic test_timeout();
    int held, pulses;
    do_reset();
    held = 0; pulses = 0;
    for (int i = 0; i < 300; i++) begin
      drive(4'b0001, 1'b0);
      if (gnt_o == 4'b0001) held++;
      if (timeout_o !== 1'b0) pulses++;
      tick();
    end
    tests++;
    if (held != 299 || pulses != 0) begin
      fails++;
      $display("FAIL hold_forever: got %0d grant cycles %0d pulses want 299 and 0", held, pulses);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1'b0);
      tick();
    end
    tests++;
    if (gnt_o !== 4'b0100) begin
      fails++; $display("FAIL reset_mid_pre: got gnt=%b want 0100", gnt_o);
    end
    #2 rst_i = 1'b1;
    #1;
    tests++;
    if ({gnt_o, gnt_idx_o, busy_o, cyc_o} !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: got gnt=%b idx=%0d busy=%b cyc=%b want 0000 3 0 0", gnt_o, gnt_idx_o, busy_o, cyc_o);
    end
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(4'b1111, 1'b0);
      tests++;
      if (gnt_o !== ((i == 0) ? 4'b0000 : 4'b0001)) begin
        fails++;
        $display("FAIL reset_mid_first c%0d: got gnt=%b want %b", i, gnt_o, (i == 0) ? 4'b0000 : 4'b0001);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] c;
    do_reset();
    c = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (c[k]) c[k] = ($urandom_range(0, 5) != 0);
        else      c[k] = ($urandom_range(0, 2) == 0);
      end
      drive(c, ($urandom_range(0, 3) == 0));
      tests++;
      if ({gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o} !== {e_gnt, e_idx, e_busy, e_cyc, e_tmo}) begin
        fails++;
        $display("FAIL random c%0d: cyc_i=%b ack=%b got gnt=%b idx=%0d busy=%b cyc=%b tmo=%b want %b %0d %b %b %b",
                 i, cyc_i, ack_i, gnt_o, gnt_idx_o, busy_o, cyc_o, timeout_o, e_gnt, e_idx, e_busy, e_cyc, e_tmo);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_no_preempt();
    test_single();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
